// File: rtl/line_sync_filter_if.sv
`default_nettype none
// ============================================================================
// Module   : line_sync_filter_if
// Brief    : Pad-side line bundle between raw bus pads and the line conditioner.
// Revision : 1.0 - initial release
// ============================================================================
interface line_sync_filter_if #(
  parameter int CHANNELS = 2
);
  logic [CHANNELS-1:0] line_in;
  logic [CHANNELS-1:0] level_out;
  logic [CHANNELS-1:0] rise_pulse;
  logic [CHANNELS-1:0] fall_pulse;
  logic                any_edge;

  modport master (
    output line_in,
    input  level_out,
    input  rise_pulse,
    input  fall_pulse,
    input  any_edge
  );

  modport slave (
    input  line_in,
    output level_out,
    output rise_pulse,
    output fall_pulse,
    output any_edge
  );
endinterface
`default_nettype wire

// File: rtl/line_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : line_sync_filter
// Brief    : Per-channel synchroniser, glitch filter and edge strobes.
// Revision : 1.0 - initial release
// ============================================================================
module line_sync_filter #(
  parameter int   CHANNELS      = 2,
  parameter int   SYNC_STAGES   = 2,
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_LEVEL   = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  line_sync_filter_if.slave  bus
);

  localparam int             CNT_W    = $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CHANNELS-1:0] rise_d_all;
  logic [CHANNELS-1:0] fall_d_all;
  logic                any_edge_d;
  logic                any_edge_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   samp_q, samp_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    // samp_q is one register past the synchroniser so a change sampled at
    // edge 0 is accepted exactly SYNC_STAGES+FILTER_CYCLES edges later.
    always_comb begin
      sync_d  = {sync_q[SYNC_STAGES-2:0], bus.line_in[i]};
      samp_d  = sync_q[SYNC_STAGES-1];
      level_d = level_q;
      cnt_d   = '0;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (samp_q != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_d = samp_q;
          rise_d  = samp_q;
          fall_d  = ~samp_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        sync_q  <= {SYNC_STAGES{RESET_LEVEL}};
        samp_q  <= RESET_LEVEL;
        level_q <= RESET_LEVEL;
        cnt_q   <= '0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
      end else begin
        sync_q  <= sync_d;
        samp_q  <= samp_d;
        level_q <= level_d;
        cnt_q   <= cnt_d;
        rise_q  <= rise_d;
        fall_q  <= fall_d;
      end
    end

    assign rise_d_all[i]     = rise_d;
    assign fall_d_all[i]     = fall_d;
    assign bus.level_out[i]  = level_q;
    assign bus.rise_pulse[i] = rise_q;
    assign bus.fall_pulse[i] = fall_q;
  end

  always_comb begin
    any_edge_d = |(rise_d_all | fall_d_all);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      any_edge_q <= 1'b0;
    end else begin
      any_edge_q <= any_edge_d;
    end
  end

  assign bus.any_edge = any_edge_q;

endmodule
`default_nettype wire

// File: tb/tb_line_sync_filter.sv
`default_nettype none
// ============================================================================
// Module   : tb_line_sync_filter
// Brief    : Scoreboard bench for line_sync_filter (4ch/2/4 and 2ch/3/1 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_line_sync_filter;

  typedef struct {
    int       cyc;
    logic [3:0] rise;
    logic [3:0] fall;
  } ev_t;

  typedef struct {
    int       ecyc;
    logic [1:0] val;
  } cs_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc;
  int   total = 0;
  int   bad   = 0;
  logic [3:0] exp_lvl;
  ev_t  sb[$];

  line_sync_filter_if #(.CHANNELS(4)) bus ();
  line_sync_filter_if #(.CHANNELS(2)) bc ();

  line_sync_filter #(
    .CHANNELS(4), .SYNC_STAGES(2), .FILTER_CYCLES(4), .RESET_LEVEL(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  line_sync_filter #(
    .CHANNELS(2), .SYNC_STAGES(3), .FILTER_CYCLES(1), .RESET_LEVEL(1'b1)
  ) dut_c (
    .clk(clk), .rst(rst), .bus(bc)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Reset holds everything at the idle level; release with lines low.
  task automatic test_reset();
    logic [3:0] pat[$];
    logic [3:0] er, ef;
    ev_t e;
    int c0;
    bus.line_in = 4'b0000;
    bc.line_in  = 2'b11;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      total++;
      if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge, bc.level_out} !== {4'hF, 4'h0, 4'h0, 1'b0, 2'b11}) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got lvl=%b r=%b f=%b a=%b lvl_c=%b exp lvl=1111 r=0000 f=0000 a=0 lvl_c=11",
                 cyc, bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge, bc.level_out);
      end
    end
    exp_lvl = 4'hF;
    rst = 1'b0;
    c0 = cyc;
    pat = {4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    sb.push_back('{c0 + 7,  4'b0000, 4'b1111});
    sb.push_back('{c0 + 15, 4'b1111, 4'b0000});
    for (int i = 0; i < 22; i++) begin
      bus.line_in = (i < pat.size()) ? pat[i] : pat[pat.size()-1];
      step();
      er = '0; ef = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); er = e.rise; ef = e.fall; end
      exp_lvl = (exp_lvl | er) & ~ef;
      total++;
      if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge} !== {exp_lvl, er, ef, |(er | ef)}) begin
        bad++;
        $display("FAIL reset_release cyc=%0d got lvl=%b r=%b f=%b a=%b exp lvl=%b r=%b f=%b a=%b",
                 cyc, bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge, exp_lvl, er, ef, |(er | ef));
      end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL reset_missing got pending=%0d exp 0", sb.size()); end
    sb.delete();
  endtask

  // 3-cycle low is rejected; 4-cycle low is accepted then returns high.
  task automatic test_glitch();
    logic [3:0] pat[$];
    logic [3:0] er, ef;
    ev_t e;
    int c0 = cyc;
    pat = {4'b1110, 4'b1110, 4'b1110, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
           4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111};
    sb.push_back('{c0 + 17, 4'b0000, 4'b0001});
    sb.push_back('{c0 + 21, 4'b0001, 4'b0000});
    for (int i = 0; i < 28; i++) begin
      bus.line_in = (i < pat.size()) ? pat[i] : pat[pat.size()-1];
      step();
      er = '0; ef = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); er = e.rise; ef = e.fall; end
      exp_lvl = (exp_lvl | er) & ~ef;
      total++;
      if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge} !== {exp_lvl, er, ef, |(er | ef)}) begin
        bad++;
        $display("FAIL glitch cyc=%0d got lvl=%b r=%b f=%b a=%b exp lvl=%b r=%b f=%b a=%b",
                 cyc, bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge, exp_lvl, er, ef, |(er | ef));
      end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL glitch_missing got pending=%0d exp 0", sb.size()); end
    sb.delete();
  endtask

  // Two 3-cycle lows split by one high cycle must never accumulate.
  task automatic test_count_discard();
    logic [3:0] pat[$];
    logic [3:0] er, ef;
    ev_t e;
    pat = {4'b1101, 4'b1101, 4'b1101, 4'b1111, 4'b1101, 4'b1101, 4'b1101, 4'b1111};
    for (int i = 0; i < 20; i++) begin
      bus.line_in = (i < pat.size()) ? pat[i] : pat[pat.size()-1];
      step();
      er = '0; ef = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); er = e.rise; ef = e.fall; end
      exp_lvl = (exp_lvl | er) & ~ef;
      total++;
      if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge} !== {exp_lvl, er, ef, |(er | ef)}) begin
        bad++;
        $display("FAIL count_discard cyc=%0d got lvl=%b r=%b f=%b a=%b exp lvl=%b r=%b f=%b a=%b",
                 cyc, bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge, exp_lvl, er, ef, |(er | ef));
      end
    end
  endtask

  // Simultaneous and staggered drops on separate channels.
  task automatic test_independent();
    logic [3:0] pat[$];
    logic [3:0] er, ef;
    ev_t e;
    int c0 = cyc;
    pat = {4'b1010, 4'b1010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010,
           4'b0010, 4'b0010, 4'b1111};
    sb.push_back('{c0 + 7,  4'b0000, 4'b0101});
    sb.push_back('{c0 + 9,  4'b0000, 4'b1000});
    sb.push_back('{c0 + 19, 4'b1101, 4'b0000});
    for (int i = 0; i < 30; i++) begin
      bus.line_in = (i < pat.size()) ? pat[i] : pat[pat.size()-1];
      step();
      er = '0; ef = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); er = e.rise; ef = e.fall; end
      exp_lvl = (exp_lvl | er) & ~ef;
      total++;
      if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge} !== {exp_lvl, er, ef, |(er | ef)}) begin
        bad++;
        $display("FAIL independent cyc=%0d got lvl=%b r=%b f=%b a=%b exp lvl=%b r=%b f=%b a=%b",
                 cyc, bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge, exp_lvl, er, ef, |(er | ef));
      end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL independent_missing got pending=%0d exp 0", sb.size()); end
    sb.delete();
  endtask

  // Reset in the middle of a filter count drops the count and emits nothing.
  task automatic test_reset_mid_filter();
    logic [3:0] pat[$];
    logic [3:0] er, ef;
    ev_t e;
    int c1;
    bus.line_in = 4'b1110;
    for (int i = 0; i < 5; i++) begin
      step();
      total++;
      if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
        bad++;
        $display("FAIL midfilter_pre cyc=%0d got lvl=%b r=%b f=%b a=%b exp lvl=1111 r=0000 f=0000 a=0",
                 cyc, bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge);
      end
    end
    rst = 1'b1;
    step();
    total++;
    if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge} !== {4'hF, 4'h0, 4'h0, 1'b0}) begin
      bad++;
      $display("FAIL midfilter_rst cyc=%0d got lvl=%b r=%b f=%b a=%b exp lvl=1111 r=0000 f=0000 a=0",
               cyc, bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge);
    end
    rst = 1'b0;
    exp_lvl = 4'hF;
    c1 = cyc;
    pat = {4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b1111};
    sb.push_back('{c1 + 7,  4'b0000, 4'b0001});
    sb.push_back('{c1 + 15, 4'b0001, 4'b0000});
    for (int i = 0; i < 22; i++) begin
      bus.line_in = (i < pat.size()) ? pat[i] : pat[pat.size()-1];
      step();
      er = '0; ef = '0;
      if (sb.size() != 0 && sb[0].cyc == cyc) begin e = sb.pop_front(); er = e.rise; ef = e.fall; end
      exp_lvl = (exp_lvl | er) & ~ef;
      total++;
      if ({bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge} !== {exp_lvl, er, ef, |(er | ef)}) begin
        bad++;
        $display("FAIL midfilter_post cyc=%0d got lvl=%b r=%b f=%b a=%b exp lvl=%b r=%b f=%b a=%b",
                 cyc, bus.level_out, bus.rise_pulse, bus.fall_pulse, bus.any_edge, exp_lvl, er, ef, |(er | ef));
      end
    end
    total++;
    if (sb.size() != 0) begin bad++; $display("FAIL midfilter_missing got pending=%0d exp 0", sb.size()); end
    sb.delete();
  endtask

  // 3-stage sync, 1-cycle filter: output is the input delayed by 4 edges.
  task automatic test_corner();
    cs_t cq[$];
    cs_t c;
    logic [1:0] cur  = 2'b11;
    logic [1:0] last = 2'b11;
    for (int i = 0; i < 80; i++) begin
      if (i < 60 && (i % 5) == 0) cur = cur ^ (2'b01 << $urandom_range(0, 1));
      bc.line_in = cur;
      cq.push_back('{cyc + 1, cur});
      step();
      if (cq.size() != 0 && cq[0].ecyc + 4 == cyc) begin
        c = cq.pop_front();
        total++;
        if ({bc.level_out, bc.rise_pulse, bc.fall_pulse, bc.any_edge} !==
            {c.val, c.val & ~last, ~c.val & last, |(c.val ^ last)}) begin
          bad++;
          $display("FAIL corner cyc=%0d got lvl=%b r=%b f=%b a=%b exp lvl=%b r=%b f=%b a=%b",
                   cyc, bc.level_out, bc.rise_pulse, bc.fall_pulse, bc.any_edge,
                   c.val, c.val & ~last, ~c.val & last, |(c.val ^ last));
        end
        last = c.val;
      end
    end
  endtask

  initial begin
    cyc = 0;
    rst = 1'b1;
    bus.line_in = 4'b0000;
    bc.line_in  = 2'b11;
    exp_lvl = 4'hF;
    test_reset();
    test_glitch();
    test_count_discard();
    test_independent();
    test_reset_mid_filter();
    test_corner();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
